// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one 32-bit word per line.
// The fetch stage presents a PC. A hit answers one cycle later. A miss issues a
// single word read to the memory controller, fills the line, and then answers.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; when low, all state and outputs hold
//   fetch_valid     fetch request; pc_to_fetch is held stable until instr_valid
//   pc_to_fetch     fetch address (bits [1:0] ignored)
//   flush           abandon the current request
//   instr_valid     one-cycle pulse; instr_fetched is valid
//   instr_fetched   instruction word
//   mem_req         read request, held until mem_ready
//   mem_addr        word-aligned read address
//   mem_ready       one-cycle pulse; mem_data is valid
//   mem_data        returned word
//
// Handshake: fetch_valid/pc_to_fetch are sampled only in IDLE and answered by
// exactly one instr_valid pulse unless flushed. mem_req stays high with a stable
// mem_addr until the cycle in which mem_ready is seen; the transfer completes on
// that edge.
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] pc_to_fetch,
  input  logic              flush,
  output logic              instr_valid,
  output logic [31:0]       instr_fetched,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  // Hierarchically visible FSM state, for checkers.
  state_t state;
  logic   drop;  // a flush arrived during MISS; swallow the response

  logic                line_valid [LINES];
  logic [TAG_BITS-1:0] line_tag   [LINES];
  logic [31:0]         line_data  [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_pc_bits;

  assign req_index = pc_to_fetch[INDEX_BITS+1:2];
  assign req_tag   = pc_to_fetch[ADDR_W-1:INDEX_BITS+2];
  // The outstanding miss address is held in mem_addr, so the fill uses it directly.
  assign fill_index = mem_addr[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr[ADDR_W-1:INDEX_BITS+2];
  assign hit        = line_valid[req_index] && (line_tag[req_index] == req_tag);
  // Leaving MISS on the fill edge guarantees that each miss writes exactly once.
  assign fill_en    = rdy && (state == MISS) && mem_ready;
  assign unused_pc_bits = ^pc_to_fetch[1:0];

  // Only the valid bits need a reset. Tag and data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) line_valid[i] <= 1'b0;
    end else if (fill_en) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      drop          <= 1'b0;
      instr_valid   <= 1'b0;
      instr_fetched <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else if (rdy) begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_valid && !flush) begin
            if (hit) begin
              state         <= RESP;
              instr_valid   <= 1'b1;
              instr_fetched <= line_data[req_index];
            end else begin
              state    <= MISS;
              mem_req  <= 1'b1;
              mem_addr <= {pc_to_fetch[ADDR_W-1:2], 2'b00};
            end
          end
        end
        MISS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            drop    <= 1'b0;
            // A flush in the same cycle as the fill also suppresses the answer.
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              state         <= RESP;
              instr_valid   <= 1'b1;
              instr_fetched <= mem_data;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_valid, flush, mem_ready;
  logic [31:0] pc_to_fetch, mem_data;
  logic        instr_valid, mem_req;
  logic [31:0] instr_fetched, mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one valid bit and one tag per index. Memory is a fixed function.
  bit          ref_v [64];
  logic [23:0] ref_t [64];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .fetch_valid(fetch_valid),
    .pc_to_fetch(pc_to_fetch), .flush(flush), .instr_valid(instr_valid),
    .instr_fetched(instr_fetched), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h100) return 32'h0000_0013;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic bit ref_hit(input logic [31:0] pc);
    return ref_v[pc[7:2]] && (ref_t[pc[7:2]] == pc[31:8]);
  endfunction

  task automatic ref_fill(input logic [31:0] pc);
    ref_v[pc[7:2]] = 1'b1;
    ref_t[pc[7:2]] = pc[31:8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch driver and memory responder. It reports what it observed. The memory
  // answers after mem_lat cycles of mem_req. flush is raised in the cycle where
  // req_cycles == flush_at (use -1 for no flush).
  task automatic run_fetch(input logic [31:0] pc, input int mem_lat, input int flush_at,
                           output bit got_resp, output logic [31:0] got_data,
                           output int lat, output int req_cycles,
                           output bit addr_err, output bit both_err);
    bit done = 0;
    got_resp = 0; got_data = '0; lat = 0; req_cycles = 0; addr_err = 0; both_err = 0;
    fetch_valid = 0; flush = 0; mem_ready = 0;
    step();
    fetch_valid = 1; pc_to_fetch = pc;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      step();
      mem_ready = 0; flush = 0; mem_data = $urandom;
      if (instr_valid && mem_req) both_err = 1;
      if (instr_valid) begin
        got_resp = 1; got_data = instr_fetched; lat = cyc; done = 1;
        break;
      end
      if (!mem_req) begin
        lat = cyc; done = 1;
        break;
      end
      req_cycles++;
      if (mem_addr !== {pc[31:2], 2'b00}) addr_err = 1;
      if (req_cycles == flush_at) flush = 1;
      if (req_cycles == mem_lat) begin
        mem_ready = 1; mem_data = mem_word(pc);
      end
    end
    fetch_valid = 0; flush = 0; mem_ready = 0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL fetch_timeout pc=%h: got no completion, required completion within 60 cycles", pc);
    end
  endtask

  task automatic test_reset();
    rdy = 0; rst = 1;
    step(); step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    n_cmp++; if (instr_fetched !== 32'h0) begin n_err++; $display("FAIL reset_instr_fetched got=%h exp=0", instr_fetched); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    rst = 0; rdy = 1;
    ref_clear();
  endtask

  task automatic test_cold_miss();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    run_fetch(32'h100, 3, -1, r, d, lat, rc, ae, be);
    n_cmp++; if (r !== 1'b1 || d !== 32'h13) begin n_err++; $display("FAIL cold_resp got=%b/%h exp=1/00000013", r, d); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL cold_latency got=%0d exp=4", lat); end
    n_cmp++; if (rc != 3 || ae) begin n_err++; $display("FAIL cold_mem_req cycles=%0d addr_err=%b exp=3/0", rc, ae); end
    n_cmp++; if (be) begin n_err++; $display("FAIL cold_overlap got=1 exp=0"); end
    ref_fill(32'h100);
  endtask

  task automatic test_hit();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    run_fetch(32'h100, 3, -1, r, d, lat, rc, ae, be);
    n_cmp++; if (r !== 1'b1 || d !== 32'h13) begin n_err++; $display("FAIL hit_resp got=%b/%h exp=1/00000013", r, d); end
    n_cmp++; if (lat != 1 || rc != 0) begin n_err++; $display("FAIL hit_latency lat=%0d req=%0d exp=1/0", lat, rc); end
  endtask

  task automatic test_conflict();
    logic [31:0] pcs [3];
    bit r, be, ae; logic [31:0] d; int lat, rc;
    pcs[0] = 32'h200; pcs[1] = 32'h100; pcs[2] = 32'h200;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ref_hit(pcs[i])) begin n_err++; $display("FAIL conflict_model pc=%h got=hit exp=miss", pcs[i]); end
      run_fetch(pcs[i], 2, -1, r, d, lat, rc, ae, be);
      n_cmp++; if (rc != 2 || ae) begin n_err++; $display("FAIL conflict_req pc=%h cycles=%0d addr_err=%b exp=2/0", pcs[i], rc, ae); end
      n_cmp++; if (!r || d !== mem_word(pcs[i]) || lat != 3) begin
        n_err++; $display("FAIL conflict_resp pc=%h got=%b/%h lat=%0d exp=1/%h lat=3", pcs[i], r, d, lat, mem_word(pcs[i]));
      end
      ref_fill(pcs[i]);
    end
  endtask

  task automatic test_flush();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    // A flush while IDLE discards the request outright.
    fetch_valid = 1; pc_to_fetch = 32'h100; flush = 1;
    step();
    fetch_valid = 0; flush = 0;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL flush_idle got iv=%b req=%b exp=0/0", instr_valid, mem_req);
    end
    // Flush one cycle before mem_ready, then flush together with mem_ready.
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pc;
      pc = (k == 0) ? 32'h404 : 32'h808;
      run_fetch(pc, 4, 3 + k, r, d, lat, rc, ae, be);
      n_cmp++; if (r || rc != 4 || ae) begin n_err++; $display("FAIL flush_miss%0d resp=%b cycles=%0d exp=0/4", k, r, rc); end
      ref_fill(pc);
      run_fetch(pc, 4, -1, r, d, lat, rc, ae, be);
      n_cmp++; if (!r || lat != 1 || d !== mem_word(pc)) begin
        n_err++; $display("FAIL flush_refetch%0d got=%b lat=%0d data=%h exp=1 lat=1 data=%h", k, r, lat, d, mem_word(pc));
      end
    end
  endtask

  task automatic test_rdy_stall();
    step();
    fetch_valid = 1; pc_to_fetch = 32'h600;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_err++; $display("FAIL stall_start req=%b addr=%h exp=1/600", mem_req, mem_addr); end
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 2); mem_data = $urandom; flush = (i == 3);
      step();
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d req=%b addr=%h iv=%b exp=1/600/0", i, mem_req, mem_addr, instr_valid);
      end
    end
    mem_ready = 0; flush = 0; rdy = 1;
    step();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_resume req=%b exp=1", mem_req); end
    mem_ready = 1; mem_data = mem_word(32'h600);
    step();
    mem_ready = 0; fetch_valid = 0;
    n_cmp++; if (instr_valid !== 1'b1 || instr_fetched !== mem_word(32'h600) || mem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_resp iv=%b data=%h req=%b exp=1/%h/0", instr_valid, instr_fetched, mem_req, mem_word(32'h600));
    end
    ref_fill(32'h600);
  endtask

  task automatic test_reset_mid_miss();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    step();
    fetch_valid = 1; pc_to_fetch = 32'h1F0;
    step(); step();
    rst = 1;
    step();
    rst = 0; fetch_valid = 0;
    n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid req=%b iv=%b exp=0/0", mem_req, instr_valid); end
    ref_clear();
    run_fetch(32'h404, 2, -1, r, d, lat, rc, ae, be);
    n_cmp++; if (rc != 2 || !r || d !== mem_word(32'h404)) begin
      n_err++; $display("FAIL rst_refetch cycles=%0d resp=%b data=%h exp=2/1/%h", rc, r, d, mem_word(32'h404));
    end
    ref_fill(32'h404);
  endtask

  task automatic test_back_to_back();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    logic [31:0] pcs [2];
    int idx = 0;
    pcs[0] = 32'h404; pcs[1] = 32'h808;
    run_fetch(32'h808, 1, -1, r, d, lat, rc, ae, be);
    ref_fill(32'h808);
    step();
    fetch_valid = 1; pc_to_fetch = pcs[0];
    for (int c = 1; c <= 6; c++) begin
      step();
      n_cmp++;
      if (instr_valid !== ((c % 2) == 1)) begin
        n_err++; $display("FAIL b2b_pulse cycle=%0d got=%b exp=%b", c, instr_valid, (c % 2) == 1);
      end else if (instr_valid && instr_fetched !== mem_word(pcs[idx])) begin
        n_err++; $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, instr_fetched, mem_word(pcs[idx]));
      end
      if (instr_valid) begin idx ^= 1; pc_to_fetch = pcs[idx]; end
    end
    fetch_valid = 0;
  endtask

  task automatic test_random();
    bit r, be, ae; logic [31:0] d; int lat, rc;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc;
      int ml, fa;
      bit h;
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      ml = $urandom_range(1, 4);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ml)) : -1;
      h = ref_hit(pc);
      run_fetch(pc, ml, fa, r, d, lat, rc, ae, be);
      n_cmp++;
      if (be) begin
        n_err++; $display("FAIL rand_overlap pc=%h iv and mem_req both high", pc);
      end else if (h) begin
        if (!r || lat != 1 || rc != 0 || d !== mem_word(pc)) begin
          n_err++; $display("FAIL rand_hit pc=%h got=%b lat=%0d req=%0d data=%h exp=1 lat=1 req=0 data=%h", pc, r, lat, rc, d, mem_word(pc));
        end
      end else if (rc != ml || ae) begin
        n_err++; $display("FAIL rand_miss_req pc=%h cycles=%0d addr_err=%b exp=%0d/0", pc, rc, ae, ml);
      end else if (fa < 0 && (!r || lat != ml + 1 || d !== mem_word(pc))) begin
        n_err++; $display("FAIL rand_miss_resp pc=%h got=%b lat=%0d data=%h exp=1 lat=%0d data=%h", pc, r, lat, d, ml + 1, mem_word(pc));
      end else if (fa >= 0 && r) begin
        n_err++; $display("FAIL rand_flush pc=%h got response exp=none", pc);
      end
      if (!h) ref_fill(pc);
    end
  endtask

  initial begin
    rst = 1; rdy = 1; fetch_valid = 0; pc_to_fetch = '0; flush = 0;
    mem_ready = 0; mem_data = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_rdy_stall();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
